// File: rtl/vga_fb_arbiter.sv
// Frame-buffer port arbiter: VGA scan-out vs queued host pixel writes.
// Optional stall counter built when VGA_FB_ARB_STATS_EN is defined.
module vga_fb_arbiter #(
  parameter int H_PIX      = 640,
  parameter int V_LINES    = 480,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              disp_valid,
  input  logic [10:0]       disp_hcnt,
  input  logic [9:0]        disp_vcnt,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic [15:0]       host_stall_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] NPIX = 32'(H_PIX * V_LINES);

  typedef enum logic {BLANK, SCAN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_scan_addr;
  logic              r_hsync;
  logic              r_vsync;

  logic              w_frame_start;
  logic              w_empty;
  logic              w_in_range;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;

  assign w_frame_start = disp_valid && (disp_hcnt == 11'd0)
                         && (disp_vcnt == 10'd0);
  assign w_empty     = (r_count == '0);
  assign w_head_addr = r_fifo_addr[r_rptr];
  assign w_head_data = r_fifo_data[r_rptr];
  assign w_in_range  = (32'(w_head_addr) < NPIX);
  assign wr_ready    = (r_count < CNT_W'(FIFO_DEPTH));
  assign w_push      = wr_valid && wr_ready;

  // Owner state register; SCAN one cycle later marks the pixel stage valid
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) r_state <= BLANK;
    else       r_state <= w_state_nxt;
  end

  // Next owner and same-cycle port arbitration (display always wins)
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    unique case (r_state)
      BLANK: if (disp_valid)  w_state_nxt = SCAN;
      SCAN:  if (!disp_valid) w_state_nxt = BLANK;
      default: w_state_nxt = BLANK;
    endcase
    if (!reset) begin
      if (disp_valid) begin
        mem_en   = 1'b1;
        mem_addr = w_frame_start ? '0 : r_scan_addr;
      end else if (!w_empty) begin
        w_pop = 1'b1;
        if (w_in_range) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = w_head_addr;
          mem_wdata = w_head_data;
        end
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage, written on accepted host requests
  always_ff @(posedge pclk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= wr_addr;
      r_fifo_data[r_wptr] <= wr_data;
    end
  end

  // Scan address: frame start reads 0 and preloads 1 for the next pixel
  always_ff @(posedge pclk or posedge reset) begin
    if (reset)              r_scan_addr <= '0;
    else if (w_frame_start) r_scan_addr <= ADDR_W'(1);
    else if (disp_valid)    r_scan_addr <= r_scan_addr + 1'b1;
  end

  // Sync delay matching the one-cycle RAM read latency
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else begin
      r_hsync <= hsync_in;
      r_vsync <= vsync_in;
    end
  end

  assign pix_valid = (r_state == SCAN);
  assign pix_data  = pix_valid ? mem_rdata : '0;
  assign hsync_out = r_hsync;
  assign vsync_out = r_vsync;

`ifdef VGA_FB_ARB_STATS_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of host cycles refused by a full FIFO, per frame
  always_ff @(posedge pclk or posedge reset) begin
    if (reset)
      r_stall_cnt <= '0;
    else if (w_frame_start)
      r_stall_cnt <= '0;
    else if (wr_valid && !wr_ready && (r_stall_cnt != 16'hFFFF))
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign host_stall_cnt = r_stall_cnt;
`else
  assign host_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter on a reduced 32x24 frame.
// Stall expectation follows VGA_FB_ARB_STATS_EN.
module tb_vga_fb_arbiter;

  localparam int H  = 32;
  localparam int V  = 24;
  localparam int AW = 19;
  localparam int DW = 12;
  localparam int NP = H * V;
  localparam int BL = 4;
`ifdef VGA_FB_ARB_STATS_EN
  localparam logic [15:0] EXP_STALL = 16'd10;
`else
  localparam logic [15:0] EXP_STALL = 16'd0;
`endif

  logic          pclk = 1'b0;
  logic          reset;
  logic          disp_valid;
  logic [10:0]   disp_hcnt;
  logic [9:0]    disp_vcnt;
  logic          hsync_in;
  logic          vsync_in;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          hsync_out;
  logic          vsync_out;
  logic [15:0]   host_stall_cnt;

  int checks   = 0;
  int failures = 0;

  vga_fb_arbiter #(
    .H_PIX(H), .V_LINES(V), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4)
  ) dut (
    .pclk(pclk), .reset(reset),
    .disp_valid(disp_valid), .disp_hcnt(disp_hcnt), .disp_vcnt(disp_vcnt),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pix_data(pix_data), .pix_valid(pix_valid),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .host_stall_cnt(host_stall_cnt)
  );

  always #5 pclk = ~pclk;

  // RAM preloaded with data = address[11:0], one-cycle read latency
  always @(posedge pclk)
    if (mem_en && !mem_we) mem_rdata <= mem_addr[11:0];

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    disp_hcnt  = '0;
    disp_vcnt  = '0;
    hsync_in   = 1'b1;
    vsync_in   = 1'b1;
    wr_valid   = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    repeat (2) tick();
    checks++;
    if ({wr_ready, pix_valid, hsync_out, vsync_out, mem_en, mem_we}
        !== 6'b101100) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=101100",
               {wr_ready, pix_valid, hsync_out, vsync_out, mem_en, mem_we});
    end
    checks++;
    if (pix_data !== 12'd0 || host_stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_data got pix=%0h stall=%0d exp=0",
               pix_data, host_stall_cnt);
    end
    reset = 1'b0;
    tick();
    disp_valid = 1'b1;
    disp_hcnt  = 11'd7;
    disp_vcnt  = 10'd3;
    hsync_in   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_addr  = AW'(50 + i);
      wr_data  = DW'(50 + i);
      tick();
    end
    wr_valid = 1'b0;
    checks++;
    if (pix_valid !== 1'b1 || hsync_out !== 1'b0) begin
      failures++;
      $display("FAIL pre_reset got pv=%b hs=%b exp pv=1 hs=0",
               pix_valid, hsync_out);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({wr_ready, pix_valid, hsync_out, mem_en} !== 4'b1010) begin
      failures++;
      $display("FAIL async_reset got=%b exp=1010",
               {wr_ready, pix_valid, hsync_out, mem_en});
    end
    tick();
    reset = 1'b0;
    idle();
    #1;
    checks++;
    if (mem_en !== 1'b0) begin
      failures++;
      $display("FAIL flushed_fifo got mem_en=%b exp=0", mem_en);
    end
    tick();
    disp_valid = 1'b1;
    #1;
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== '0) begin
      failures++;
      $display("FAIL frame_start_rd got en=%b we=%b addr=%0d exp 1 0 0",
               mem_en, mem_we, mem_addr);
    end
    tick();
    disp_hcnt = 11'd1;
    #1;
    checks++;
    if (mem_addr !== AW'(1) || pix_valid !== 1'b1 || pix_data !== 12'd0) begin
      failures++;
      $display("FAIL second_rd got addr=%0d pv=%b pix=%0h exp 1 1 0",
               mem_addr, pix_valid, pix_data);
    end
    tick();
    checks++;
    if (pix_data !== 12'd1) begin
      failures++;
      $display("FAIL second_pix got=%0h exp=1", pix_data);
    end
    idle();
    repeat (3) tick();
  endtask

  task automatic test_full_frame();
    int          exp_addr = 0;
    int          last_rd  = -1;
    logic        valid;
    logic [11:0] exp_pix;
    for (int v = 0; v < V; v++) begin
      for (int h = 0; h < H + BL; h++) begin
        valid      = (h < H);
        disp_valid = valid;
        disp_hcnt  = 11'(h);
        disp_vcnt  = 10'(v);
        hsync_in   = !(h == H + 1 || h == H + 2);
        vsync_in   = !(v == V - 1 && h >= H);
        #1;
        checks++;
        if (valid) begin
          if (mem_en !== 1'b1 || mem_we !== 1'b0 ||
              mem_addr !== AW'(exp_addr)) begin
            failures++;
            $display("FAIL scan_rd v=%0d h=%0d got en=%b we=%b addr=%0d exp=%0d",
                     v, h, mem_en, mem_we, mem_addr, exp_addr);
          end
          last_rd = int'(mem_addr);
        end else if (mem_en !== 1'b0) begin
          failures++;
          $display("FAIL blank_idle v=%0d h=%0d got mem_en=%b exp=0",
                   v, h, mem_en);
        end
        tick();
        exp_pix = valid ? 12'(exp_addr) : 12'd0;
        checks++;
        if (pix_valid !== valid || pix_data !== exp_pix ||
            hsync_out !== hsync_in || vsync_out !== vsync_in) begin
          failures++;
          $display("FAIL pix_out v=%0d h=%0d got pv=%b pix=%0h hs=%b vs=%b exp %b %0h %b %b",
                   v, h, pix_valid, pix_data, hsync_out, vsync_out,
                   valid, exp_pix, hsync_in, vsync_in);
        end
        if (valid) exp_addr++;
      end
    end
    checks++;
    if (last_rd != NP - 1) begin
      failures++;
      $display("FAIL last_pixel got=%0d exp=%0d", last_rd, NP - 1);
    end
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    disp_valid = 1'b1;
    disp_hcnt  = 11'd3;
    disp_vcnt  = 10'd3;
    for (int k = 0; k < 6; k++) begin
      wr_valid = 1'b1;
      wr_addr  = AW'(100 + idx);
      wr_data  = DW'(256 + idx);
      #1;
      checks++;
      if (wr_ready !== (k < 4) || mem_we !== 1'b0) begin
        failures++;
        $display("FAIL active_ready k=%0d got rdy=%b we=%b exp rdy=%b we=0",
                 k, wr_ready, mem_we, (k < 4));
      end
      if (wr_ready) idx++;
      tick();
    end
    disp_valid = 1'b0;
    for (int j = 0; j < 7; j++) begin
      wr_valid = (idx < 6);
      wr_addr  = AW'(100 + idx);
      wr_data  = DW'(256 + idx);
      #1;
      checks++;
      if (j < 6) begin
        if (mem_en !== 1'b1 || mem_we !== 1'b1 ||
            mem_addr !== AW'(100 + j) || mem_wdata !== DW'(256 + j)) begin
          failures++;
          $display("FAIL drain j=%0d got en=%b we=%b addr=%0d data=%0h exp addr=%0d",
                   j, mem_en, mem_we, mem_addr, mem_wdata, 100 + j);
        end
      end else if (mem_en !== 1'b0) begin
        failures++;
        $display("FAIL drain_empty got mem_en=%b exp=0", mem_en);
      end
      checks++;
      if (wr_ready !== (j != 0)) begin
        failures++;
        $display("FAIL blank_ready j=%0d got=%b exp=%b", j, wr_ready, (j != 0));
      end
      if (wr_valid && wr_ready) idx++;
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_out_of_range();
    logic [AW-1:0] a_lst [3];
    logic [DW-1:0] d_lst [3];
    a_lst[0] = AW'(NP);
    a_lst[1] = AW'(5);
    a_lst[2] = AW'(NP - 1);
    d_lst[0] = 12'hABC;
    d_lst[1] = 12'h055;
    d_lst[2] = 12'h7FF;
    for (int c = 0; c < 5; c++) begin
      wr_valid = (c < 3);
      wr_addr  = (c < 3) ? a_lst[c] : '0;
      wr_data  = (c < 3) ? d_lst[c] : '0;
      #1;
      checks++;
      if (c >= 2 && c <= 3) begin
        if (mem_en !== 1'b1 || mem_we !== 1'b1 ||
            mem_addr !== a_lst[c-1] || mem_wdata !== d_lst[c-1]) begin
          failures++;
          $display("FAIL oob_next c=%0d got en=%b we=%b addr=%0d data=%0h exp addr=%0d",
                   c, mem_en, mem_we, mem_addr, mem_wdata, a_lst[c-1]);
        end
      end else if (mem_en !== 1'b0) begin
        failures++;
        $display("FAIL oob_idle c=%0d got mem_en=%b exp=0", c, mem_en);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_blank_to_active();
    disp_valid = 1'b1;
    disp_hcnt  = 11'd5;
    disp_vcnt  = 10'd5;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_addr  = AW'(200 + i);
      wr_data  = DW'(12'h200 + i);
      tick();
    end
    wr_valid   = 1'b0;
    disp_valid = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== AW'(200)) begin
      failures++;
      $display("FAIL last_blank_wr got we=%b addr=%0d exp we=1 addr=200",
               mem_we, mem_addr);
    end
    tick();
    for (int h = 0; h < 2; h++) begin
      disp_valid = 1'b1;
      disp_hcnt  = 11'(h);
      disp_vcnt  = 10'd0;
      #1;
      checks++;
      if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== AW'(h)) begin
        failures++;
        $display("FAIL edge_rd h=%0d got en=%b we=%b addr=%0d exp 1 0 %0d",
                 h, mem_en, mem_we, mem_addr, h);
      end
      tick();
    end
    disp_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      checks++;
      if (j < 2) begin
        if (mem_we !== 1'b1 || mem_addr !== AW'(201 + j) ||
            mem_wdata !== DW'(12'h201 + j)) begin
          failures++;
          $display("FAIL held_wr j=%0d got we=%b addr=%0d data=%0h exp addr=%0d",
                   j, mem_we, mem_addr, mem_wdata, 201 + j);
        end
      end else if (mem_en !== 1'b0) begin
        failures++;
        $display("FAIL held_empty got mem_en=%b exp=0", mem_en);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_stats();
    disp_valid = 1'b1;
    disp_hcnt  = 11'd0;
    disp_vcnt  = 10'd0;
    tick();
    for (int i = 0; i < 4; i++) begin
      disp_hcnt = 11'(1 + i);
      wr_valid  = 1'b1;
      wr_addr   = AW'(300 + i);
      wr_data   = DW'(i);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      disp_hcnt = 11'(5 + i);
      #1;
      checks++;
      if (wr_ready !== 1'b0) begin
        failures++;
        $display("FAIL full_ready i=%0d got=%b exp=0", i, wr_ready);
      end
      tick();
    end
    wr_valid = 1'b0;
    checks++;
    if (host_stall_cnt !== EXP_STALL) begin
      failures++;
      $display("FAIL stall_cnt got=%0d exp=%0d", host_stall_cnt, EXP_STALL);
    end
    disp_hcnt = 11'd0;
    disp_vcnt = 10'd0;
    tick();
    checks++;
    if (host_stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL stall_clear got=%0d exp=0", host_stall_cnt);
    end
    idle();
    repeat (5) tick();
    checks++;
    if (wr_ready !== 1'b1 || mem_en !== 1'b0) begin
      failures++;
      $display("FAIL stats_drain got rdy=%b en=%b exp 1 0", wr_ready, mem_en);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_back_to_back();
    test_out_of_range();
    test_blank_to_active();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
